// File: rtl/except_commit_ctrl.sv
// Exception commit controller: latches a MEM-stage exception, waits for the data bus to drain,
// then issues one registered commit cycle (flush, redirect, CP0 update strobes).
module except_commit_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] badvaddr_i,
   input  logic        in_delayslot_i,
   input  logic        bus_busy_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_epc_i,
   output logic        stall_o,
   output logic        flush_o,
   output logic [31:0] newpc_o,
   output logic        newpc_valid_o,
   output logic        exc_we_o,
   output logic        epc_we_o,
   output logic [31:0] epc_o,
   output logic        badvaddr_we_o,
   output logic [31:0] badvaddr_o,
   output logic [4:0]  exc_code_o,
   output logic        exc_bd_o,
   output logic        eret_o
);

   typedef enum logic [1:0] {StIdle, StWaitBus, StCommit} state_e;

   state_e      r_state, w_state_d;
   logic        w_take;
   logic [31:0] r_type, r_pc, r_badv, r_epc;
   logic        r_bd, r_bev, r_exl;

   logic        w_commit, w_is_eret, w_badv_en, w_badv_pc, w_refill;
   logic [4:0]  w_code;
   logic [31:0] w_vector, w_epc;
   logic        w_unused_status;

   assign w_unused_status = ^{cp0_status_i[31:23], cp0_status_i[21:2], cp0_status_i[0]};

   always_comb begin
      w_state_d = r_state;
      w_take    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (excepttype_i != 32'd0) begin
               w_take    = 1'b1;
               w_state_d = bus_busy_i ? StWaitBus : StCommit;
            end
         end
         StWaitBus: if (!bus_busy_i) w_state_d = StCommit;
         StCommit:  w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_code    = 5'd10;
      w_badv_en = 1'b0;
      w_badv_pc = 1'b0;
      unique case (r_type)
         32'h01: w_code = 5'd0;
         32'h04: begin w_code = 5'd4; w_badv_en = 1'b1; w_badv_pc = 1'b1; end
         32'h05: begin w_code = 5'd5; w_badv_en = 1'b1; end
         32'h08: w_code = 5'd8;
         32'h09: w_code = 5'd9;
         32'h0a: w_code = 5'd10;
         32'h0b: w_code = 5'd11;
         32'h0c: w_code = 5'd12;
         32'h0d: w_code = 5'd13;
         32'h10, 32'h11: begin w_code = 5'd2; w_badv_en = 1'b1; w_badv_pc = 1'b1; end
         32'h12: begin w_code = 5'd2; w_badv_en = 1'b1; end
         32'h13: begin w_code = 5'd3; w_badv_en = 1'b1; end
         32'h14: begin w_code = 5'd1; w_badv_en = 1'b1; end
         default: w_code = 5'd10;  // unlisted codes commit as RI
      endcase
   end

   assign w_commit  = (r_state == StCommit);
   assign w_is_eret = (r_type == 32'h0e);
   assign w_refill  = ((r_type == 32'h10) || (r_type == 32'h12) || (r_type == 32'h13)) && !r_exl;
   assign w_vector  = r_bev ? (w_refill ? 32'hBFC0_0200 : 32'hBFC0_0380)
                            : (w_refill ? 32'h8000_0000 : 32'h8000_0180);
   assign w_epc     = r_bd ? (r_pc - 32'd4) : r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_type        <= '0;
         r_pc          <= '0;
         r_badv        <= '0;
         r_epc         <= '0;
         r_bd          <= 1'b0;
         r_bev         <= 1'b0;
         r_exl         <= 1'b0;
         stall_o       <= 1'b0;
         flush_o       <= 1'b0;
         newpc_o       <= '0;
         newpc_valid_o <= 1'b0;
         exc_we_o      <= 1'b0;
         epc_we_o      <= 1'b0;
         epc_o         <= '0;
         badvaddr_we_o <= 1'b0;
         badvaddr_o    <= '0;
         exc_code_o    <= '0;
         exc_bd_o      <= 1'b0;
         eret_o        <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_take) begin
            r_type <= excepttype_i;
            r_pc   <= pc_i;
            r_badv <= badvaddr_i;
            r_epc  <= cp0_epc_i;
            r_bd   <= in_delayslot_i;
            r_bev  <= cp0_status_i[22];
            r_exl  <= cp0_status_i[1];
         end
         // Stall spans the whole hold plus the cycle the commit outputs are presented.
         stall_o       <= (w_state_d != StIdle) || w_commit;
         flush_o       <= w_commit;
         newpc_valid_o <= w_commit;
         newpc_o       <= w_commit ? (w_is_eret ? r_epc : w_vector) : '0;
         exc_we_o      <= w_commit && !w_is_eret;
         epc_we_o      <= w_commit && !w_is_eret && !r_exl;
         epc_o         <= (w_commit && !w_is_eret) ? w_epc : '0;
         badvaddr_we_o <= w_commit && w_badv_en;
         badvaddr_o    <= (w_commit && w_badv_en) ? (w_badv_pc ? r_pc : r_badv) : '0;
         exc_code_o    <= (w_commit && !w_is_eret) ? w_code : '0;
         exc_bd_o      <= w_commit && !w_is_eret && r_bd;
         eret_o        <= w_commit && w_is_eret;
      end
   end

endmodule

// File: doc/except_commit_ctrl.md
EXCEPT_COMMIT_CTRL -- requirements
Module: except_commit_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 excepttype_i  in  32  encoded exception from MEM stage: 0=none, 0x1 Int, 0x4 AdEL, 0x5 AdES, 0x8 Sys, 0x9 Bp, 0xa RI, 0xb CpU, 0xc Ov, 0xd Tr, 0xe ERET, 0x10 ITLB refill, 0x11 ITLB invalid, 0x12 DTLB load, 0x13 DTLB store, 0x14 TLB modified.
REQ-004 pc_i  in  32  PC of the excepting instruction.
REQ-005 badvaddr_i  in  32  faulting virtual address for address/TLB exceptions.
REQ-006 in_delayslot_i  in  1  excepting instruction sits in a branch delay slot.
REQ-007 bus_busy_i  in  1  outstanding data-bus transaction not yet retired.
REQ-008 cp0_status_i  in  32  current Status (bit22 BEV, bit1 EXL used).
REQ-009 cp0_epc_i  in  32  current EPC.
REQ-010 stall_o  out  1  hold all pipeline stages.
REQ-011 flush_o  out  1  one-cycle flush of all stages.
REQ-012 newpc_o  out  32  redirect target; newpc_valid_o  out  1  redirect strobe.
REQ-013 exc_we_o  out  1  CP0 exception update strobe (Cause.ExcCode/BD, Status.EXL set).
REQ-014 epc_we_o  out  1  EPC write strobe; epc_o  out  32  EPC value.
REQ-015 badvaddr_we_o  out  1  BadVAddr write strobe; badvaddr_o  out  32.
REQ-016 exc_code_o  out  5  Cause.ExcCode; exc_bd_o  out  1  Cause.BD.
REQ-017 eret_o  out  1  ERET commit strobe (Status.EXL clear).

Function
REQ-018 States SHALL be IDLE, WAIT_BUS, COMMIT; state, latched exception fields and all outputs registered.
REQ-019 In IDLE with excepttype_i!=0, SHALL latch excepttype_i, pc_i, badvaddr_i, in_delayslot_i, cp0_status_i, cp0_epc_i, and go to WAIT_BUS if bus_busy_i=1, else COMMIT.
REQ-020 In IDLE with excepttype_i=0, SHALL stay IDLE with all strobes low.
REQ-021 stall_o SHALL be 1 in every cycle the state is WAIT_BUS or COMMIT, 0 in IDLE.
REQ-022 WAIT_BUS SHALL go to COMMIT the cycle after bus_busy_i is sampled 0; no cycle limit.
REQ-023 COMMIT SHALL last exactly one cycle, then IDLE; flush_o and newpc_valid_o SHALL be 1 only in COMMIT.
REQ-024 Minimum latency: excepttype_i sampled at edge N with bus idle -> flush_o/newpc_valid_o high during cycle N+1..N+2.
REQ-025 excepttype_i changes while in WAIT_BUS or COMMIT SHALL be ignored.
REQ-026 ExcCode map: Int 0, 0x14 1, 0x10/0x11/0x12 2, 0x13 3, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, CpU 11, Ov 12, Tr 13.
REQ-027 Non-ERET COMMIT: exc_we_o=1; epc_we_o=1 only if latched EXL=0; epc_o=pc-4 when delay slot else pc; exc_bd_o=delay slot flag.
REQ-028 badvaddr_we_o=1 in COMMIT for 0x4, 0x5, 0x10-0x14; badvaddr_o=latched badvaddr, except 0x4 with 0x10/0x11 fetch-origin use latched pc.
REQ-029 Vector: refill (0x10, 0x12, 0x13 with EXL=0) -> BEV ? 0xBFC00200 : 0x80000000; all others -> BEV ? 0xBFC00380 : 0x80000180.
REQ-030 ERET (0xe) COMMIT: eret_o=1, newpc_o=latched EPC, exc_we_o=epc_we_o=badvaddr_we_o=0.
REQ-031 Unlisted nonzero excepttype SHALL commit as RI (code 10) to general vector.
REQ-032 Address arithmetic SHALL be 32-bit modulo (pc=0 in delay slot -> epc 0xFFFFFFFC).

Reset
REQ-033 rst=1 SHALL immediately force IDLE and all outputs/latches to 0, including mid-WAIT_BUS or mid-COMMIT; no strobe SHALL fire for the aborted exception after release.
REQ-034 First edge after rst deasserts SHALL sample excepttype_i normally.

Verification
REQ-035 Sys, pc=0x80001000, BD=0, EXL=0, BEV=0, bus idle -> next cycle COMMIT: exc_code 8, epc 0x80001000, newpc 0x80000180, stall 2 cycles.
REQ-036 AdES, BD=1, pc=0x80002004, badvaddr=0x1003, bus_busy 3 cycles -> stall 5 cycles, epc 0x80002000, badvaddr_we=1 value 0x1003, code 5.
REQ-037 DTLB store (0x13), EXL=1, BEV=1 -> code 3, epc_we_o=0, newpc 0xBFC00380.
REQ-038 ERET, cp0_epc_i=0x80003000 -> eret_o=1, newpc 0x80003000, exc_we_o=0.
REQ-039 rst pulsed during WAIT_BUS -> all outputs 0 immediately, no flush after release.
REQ-040 Int followed by Ov on next cycle -> only Int committed (code 0), Ov ignored.
